// File: rtl/cpu_trace_streamer_pkg.sv
// Shared constants, state encoding and frame geometry for the CPU trace streamer.
package cpu_trace_pkg;

  localparam logic [7:0] TRACE_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  // Header word layout: {magic, seq, frame length in words}
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int HDR_LEN_LSB   = 0;

  // Words before the register dump: header, cycle, stall, flush, pc
  localparam int HDR_WORDS = 5;

  function automatic int frame_words(input int num_regs, input int num_mem_words);
    return HDR_WORDS + num_regs + num_mem_words;
  endfunction

endpackage

// File: rtl/cpu_trace_streamer_if.sv
// Trace word stream. A word moves when trace_valid and trace_ready are both high at a clk edge;
// the master keeps data/last stable and valid high until that transfer happens.
interface cpu_trace_if #(
  parameter int DATA_W = 32
);
  logic              trace_valid;
  logic              trace_ready;
  logic [DATA_W-1:0] trace_data;
  logic              trace_last;

  modport master (
    output trace_valid,
    output trace_data,
    output trace_last,
    input  trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_data,
    input  trace_last,
    output trace_ready
  );

endinterface

// File: rtl/cpu_trace_streamer_counter.sv
// Enable-gated wrapping event counter used for the cycle, stall and flush tallies.
module trace_event_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_trace_streamer.sv
// Single-steps the CPU and streams one trace frame (counters, PC, registers, data memory)
// per CPU cycle over a valid/ready word stream.
module cpu_trace_streamer
  import cpu_trace_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 8,
  parameter int NUM_CYCLES    = 64,
  parameter int DATA_W        = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic              flush_i,
  output logic [4:0]        reg_rd_addr_o,
  input  logic [DATA_W-1:0] reg_rd_data_i,
  output logic [7:0]        mem_rd_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              cpu_hold_o,
  cpu_trace_if.master       trace,
  output logic              done_o,
  output logic [1:0]        state_o
);

  localparam int FRAME_WORDS = frame_words(NUM_REGS, NUM_MEM_WORDS);
  localparam int REG_END     = HDR_WORDS + NUM_REGS;
  localparam int WW          = $clog2(FRAME_WORDS + 1);
  localparam int FCW         = $clog2(NUM_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_FRAME = ST_FRAME;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]        state_q, state_d;
  logic [WW-1:0]     w_q, w_d;
  logic [7:0]        seq_q, seq_d;
  logic [FCW-1:0]    frames_q, frames_d;
  logic [FCW-1:0]    frames_nxt;

  logic              xfer;
  logic              is_last;
  logic              hdr_xfer;
  logic              last_xfer;
  logic [DATA_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] hdr;

  assign xfer       = (state_q == S_FRAME) && trace.trace_ready;
  assign is_last    = (w_q == WW'(FRAME_WORDS - 1));
  assign hdr_xfer   = xfer && (w_q == '0);
  assign last_xfer  = xfer && is_last;
  assign frames_nxt = frames_q + FCW'(1);

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    seq_d    = seq_q;
    frames_d = frames_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FRAME;
      end
      S_FRAME: begin
        if (xfer) begin
          if (is_last) begin
            w_d      = '0;
            seq_d    = seq_q + 8'd1;
            frames_d = frames_nxt;
            if (frames_nxt == FCW'(NUM_CYCLES)) state_d = S_DONE;
            else if (start_i)                   state_d = S_RUN;
            else                                state_d = S_IDLE;
          end else begin
            w_d = w_q + WW'(1);
          end
        end
      end
      S_RUN:   state_d = S_FRAME;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      w_q      <= '0;
      seq_q    <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      seq_q    <= seq_d;
      frames_q <= frames_d;
    end
  end

  // Stall/flush are sampled once per frame while the CPU is frozen, so the header
  // transfer is a safe single point to count them.
  trace_event_counter #(.W(DATA_W)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (last_xfer),
    .cnt_o (cycle_cnt)
  );

  trace_event_counter #(.W(DATA_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (hdr_xfer && stall_i && !branch_i),
    .cnt_o (stall_cnt)
  );

  trace_event_counter #(.W(DATA_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (hdr_xfer && flush_i),
    .cnt_o (flush_cnt)
  );

  always_comb begin
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: 8] = TRACE_MAGIC;
    hdr[HDR_SEQ_LSB +: 8]   = seq_q;
    hdr[HDR_LEN_LSB +: 16]  = 16'(FRAME_WORDS);
  end

  // Word mux: addresses are decoded from w_q only, so they stay put while the receiver stalls.
  always_comb begin
    data          = '0;
    reg_rd_addr_o = '0;
    mem_rd_addr_o = '0;
    if (state_q == S_FRAME) begin
      if (w_q == WW'(0))      data = hdr;
      else if (w_q == WW'(1)) data = cycle_cnt;
      else if (w_q == WW'(2)) data = stall_cnt;
      else if (w_q == WW'(3)) data = flush_cnt;
      else if (w_q == WW'(4)) data = pc_i;
      else if (w_q < WW'(REG_END)) begin
        reg_rd_addr_o = 5'(w_q - WW'(HDR_WORDS));
        data          = reg_rd_data_i;
      end else begin
        mem_rd_addr_o = 8'(w_q - WW'(REG_END));
        data          = mem_rd_data_i;
      end
    end
  end

  assign trace.trace_valid = (state_q == S_FRAME);
  assign trace.trace_data  = data;
  assign trace.trace_last  = (state_q == S_FRAME) && is_last;
  assign cpu_hold_o        = (state_q != S_RUN);
  assign done_o            = (state_q == S_DONE);
  assign state_o           = state_q;

endmodule

// File: tb/tb_cpu_trace_streamer.sv
// Bench for cpu_trace_streamer: models the CPU side (PC, register file, data memory) and a receiver.
module tb_cpu_trace_streamer;

  localparam int FW = 45;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic        branch;
  logic        flush;
  logic [31:0] pc;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        hold;
  logic        done;
  logic [1:0]  state;

  logic [31:0] regs [32];
  logic [31:0] mem  [8];

  logic [31:0] rx_words [FW];
  int          rx_count;
  int          last_err;
  int          stable_err;
  int          errors;
  int          checks;

  cpu_trace_if #(.DATA_W(32)) tif ();

  cpu_trace_streamer #(
    .NUM_REGS      (32),
    .NUM_MEM_WORDS (8),
    .NUM_CYCLES    (3),
    .DATA_W        (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .pc_i          (pc),
    .stall_i       (stall),
    .branch_i      (branch),
    .flush_i       (flush),
    .reg_rd_addr_o (reg_addr),
    .reg_rd_data_i (reg_data),
    .mem_rd_addr_o (mem_addr),
    .mem_rd_data_i (mem_data),
    .cpu_hold_o    (hold),
    .trace         (tif),
    .done_o        (done),
    .state_o       (state)
  );

  // Clock and CPU model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst)       pc <= 32'd0;
    else if (!hold) pc <= pc + 32'd4;
  end

  assign reg_data = regs[reg_addr];
  assign mem_data = (mem_addr < 8'd8) ? mem[mem_addr[2:0]] : 32'hDEAD_BEEF;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0100_0000 + i;
    regs[0] = 32'd0;
    regs[5] = 32'd7;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0200_0000 + i;
    mem[0] = 32'd5;
  end

  // Driver tasks
  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0; flush = 1'b0;
    tif.trace_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // mode 0: ready high, 1: toggling, 2: random. abort_idx asserts reset once that many
  // words are in; drop_idx lowers start_i at that word count.
  task automatic receive_frame(input int mode, input int abort_idx, input int drop_idx,
                               output logic timeout);
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        r;
    logic        fin;
    timeout = 1'b1; fin = 1'b0;
    rx_count = 0; last_err = 0; stable_err = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (rx_count == abort_idx && tif.trace_valid) begin
        tif.trace_ready = 1'b0;
        rst = 1'b1;
        timeout = 1'b0;
        break;
      end
      if (rx_count == drop_idx) start = 1'b0;
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2) == 0;
        default: r = 1'($urandom_range(0, 1));
      endcase
      tif.trace_ready = r;
      if (prev_stall && tif.trace_valid &&
          (tif.trace_data !== prev_data || tif.trace_last !== prev_last))
        stable_err++;
      if (tif.trace_valid && r) begin
        rx_words[rx_count] = tif.trace_data;
        if (tif.trace_last !== (rx_count == FW - 1)) last_err++;
        rx_count++;
        prev_stall = 1'b0;
        if (rx_count == FW) begin
          timeout = 1'b0;
          fin = 1'b1;
        end
      end else begin
        prev_stall = tif.trace_valid;
        prev_data  = tif.trace_data;
        prev_last  = tif.trace_last;
      end
      if (fin) break;
    end
    @(posedge clk);
    #1 tif.trace_ready = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0; flush = 1'b0;
    tif.trace_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tif.trace_valid, tif.trace_last, hold, done} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_flags got valid/last/hold/done=%b want 0010",
               {tif.trace_valid, tif.trace_last, hold, done});
    end
    checks++;
    if (tif.trace_data !== 32'd0 || reg_addr !== 5'd0 || mem_addr !== 8'd0 || state !== 2'd0) begin
      errors++;
      $display("FAIL reset_data got data=%h reg=%0d mem=%0d state=%0d want 0",
               tif.trace_data, reg_addr, mem_addr, state);
    end
  endtask

  task automatic test_basic_frame();
    logic to;
    apply_reset();
    start = 1'b1;
    receive_frame(0, -1, -1, to);
    checks++;
    if (to || rx_count != FW) begin
      errors++; $display("FAIL basic_count got %0d words want %0d", rx_count, FW);
    end
    checks++;
    if (rx_words[0] !== 32'hA500_002D) begin
      errors++; $display("FAIL basic_hdr got %h want a500002d", rx_words[0]);
    end
    checks++;
    if (rx_words[1] !== 32'd0 || rx_words[4] !== 32'd0) begin
      errors++; $display("FAIL basic_cyc_pc got w1=%h w4=%h want 0 0", rx_words[1], rx_words[4]);
    end
    checks++;
    if (last_err != 0) begin
      errors++; $display("FAIL basic_last got %0d misplaced last want 0", last_err);
    end
    @(negedge clk);
    checks++;
    if (hold !== 1'b0 || state !== 2'd2 || tif.trace_valid !== 1'b0) begin
      errors++; $display("FAIL run_cycle got hold=%b state=%0d valid=%b want 0 2 0",
                         hold, state, tif.trace_valid);
    end
    @(negedge clk);
    checks++;
    if (hold !== 1'b1 || tif.trace_valid !== 1'b1) begin
      errors++; $display("FAIL run_one got hold=%b valid=%b want 1 1", hold, tif.trace_valid);
    end
    receive_frame(0, -1, -1, to);
    checks++;
    if (rx_words[0] !== 32'hA501_002D || rx_words[1] !== 32'd1 || rx_words[4] !== 32'd4) begin
      errors++; $display("FAIL frame1 got w0=%h w1=%h w4=%h want a501002d 1 4",
                         rx_words[0], rx_words[1], rx_words[4]);
    end
  endtask

  task automatic test_backpressure();
    logic        to;
    logic [31:0] exp;
    apply_reset();
    start = 1'b1;
    receive_frame(1, -1, -1, to);
    checks++;
    if (to || rx_words[10] !== 32'd7 || rx_words[37] !== 32'd5) begin
      errors++; $display("FAIL preload got w10=%h w37=%h want 7 5", rx_words[10], rx_words[37]);
    end
    checks++;
    if (stable_err != 0 || last_err != 0) begin
      errors++; $display("FAIL toggle_stable got unstable=%0d last_err=%0d want 0 0",
                         stable_err, last_err);
    end
    receive_frame(2, -1, -1, to);
    checks++;
    if (to || rx_count != FW || stable_err != 0 || last_err != 0) begin
      errors++; $display("FAIL random_stream got count=%0d unstable=%0d last_err=%0d want 45 0 0",
                         rx_count, stable_err, last_err);
    end
    for (int w = 0; w < FW; w++) begin
      if (w == 0)      exp = 32'hA501_002D;
      else if (w == 1) exp = 32'd1;
      else if (w < 4)  exp = 32'd0;
      else if (w == 4) exp = 32'd4;
      else if (w == 5) exp = 32'd0;
      else if (w == 10) exp = 32'd7;
      else if (w < 37) exp = 32'h0100_0000 + 32'(w - 5);
      else if (w == 37) exp = 32'd5;
      else             exp = 32'h0200_0000 + 32'(w - 37);
      checks++;
      if (rx_words[w] !== exp) begin
        errors++; $display("FAIL random_word%0d got %h want %h", w, rx_words[w], exp);
      end
    end
  endtask

  task automatic test_counters();
    logic to;
    apply_reset();
    stall = 1'b1; branch = 1'b0; start = 1'b1;
    receive_frame(0, -1, -1, to);
    checks++;
    if (to || rx_words[2] !== 32'd1 || rx_words[3] !== 32'd0) begin
      errors++; $display("FAIL stall_cnt got w2=%h w3=%h want 1 0", rx_words[2], rx_words[3]);
    end
    branch = 1'b1; flush = 1'b1;
    receive_frame(0, -1, -1, to);
    checks++;
    if (rx_words[2] !== 32'd1 || rx_words[3] !== 32'd1) begin
      errors++; $display("FAIL branch_flush got w2=%h w3=%h want 1 1", rx_words[2], rx_words[3]);
    end
    branch = 1'b0; flush = 1'b0;
    receive_frame(0, -1, -1, to);
    checks++;
    if (rx_words[2] !== 32'd2 || rx_words[3] !== 32'd1) begin
      errors++; $display("FAIL stall_again got w2=%h w3=%h want 2 1", rx_words[2], rx_words[3]);
    end
    stall = 1'b0;
  endtask

  task automatic test_done();
    logic to;
    apply_reset();
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      receive_frame(0, -1, -1, to);
      checks++;
      if (to || rx_words[0] !== (32'hA500_002D | (32'(k) << 16)) || rx_words[1] !== 32'(k)
          || rx_words[4] !== 32'(4 * k)) begin
        errors++; $display("FAIL done_frame%0d got w0=%h w1=%h w4=%h", k, rx_words[0],
                           rx_words[1], rx_words[4]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || hold !== 1'b1 || tif.trace_valid !== 1'b0 || state !== 2'd3) begin
      errors++; $display("FAIL done_state got done=%b hold=%b valid=%b state=%0d want 1 1 0 3",
                         done, hold, tif.trace_valid, state);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (tif.trace_valid !== 1'b0 || done !== 1'b1) begin
        errors++; $display("FAIL done_sticky got valid=%b done=%b want 0 1", tif.trace_valid, done);
      end
    end
  endtask

  task automatic test_abort();
    logic to;
    apply_reset();
    stall = 1'b1; start = 1'b1;
    receive_frame(0, 10, -1, to);
    @(negedge clk);
    checks++;
    if (to || tif.trace_valid !== 1'b0 || hold !== 1'b1 || state !== 2'd0) begin
      errors++; $display("FAIL abort got valid=%b hold=%b state=%0d want 0 1 0",
                         tif.trace_valid, hold, state);
    end
    stall = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    receive_frame(0, -1, -1, to);
    checks++;
    if (to || rx_words[0] !== 32'hA500_002D || rx_words[1] !== 32'd0 || rx_words[2] !== 32'd0) begin
      errors++; $display("FAIL after_abort got w0=%h w1=%h w2=%h want a500002d 0 0",
                         rx_words[0], rx_words[1], rx_words[2]);
    end
  endtask

  task automatic test_start_drop();
    logic to;
    apply_reset();
    start = 1'b1;
    receive_frame(0, -1, 20, to);
    checks++;
    if (to || rx_count != FW || last_err != 0) begin
      errors++; $display("FAIL drop_frame got count=%0d last_err=%0d want 45 0", rx_count, last_err);
    end
    @(negedge clk);
    checks++;
    if (hold !== 1'b1 || tif.trace_valid !== 1'b0 || state !== 2'd0) begin
      errors++; $display("FAIL drop_idle got hold=%b valid=%b state=%0d want 1 0 0",
                         hold, tif.trace_valid, state);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (hold !== 1'b1 || pc !== 32'd0) begin
      errors++; $display("FAIL drop_norun got hold=%b pc=%h want 1 0", hold, pc);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_counters();
    test_done();
    test_abort();
    test_start_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
